// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared address-event bus types, defaults and decode helper
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } aer_state_t;

    localparam int AER_ADDR_W    = 4;
    localparam int AER_N_NEURONS = 16;

    // One bit of a one-hot decode: high when the event address selects this line
    function automatic logic aer_onehot_bit(input int addr, input int line);
        return addr == line;
    endfunction

endpackage

// File: rtl/aer_req_sync.sv
// rtl/aer_req_sync.sv - two-flop synchronizer for a request from another clock domain
module aer_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/aer_receiver.sv
// rtl/aer_receiver.sv - AER bus receiver: request/ack handshake to one-hot spike pulses (AER_RX_SYNC_EN adds a request synchronizer)
module aer_receiver
    import aer_pkg::*;
#(
    parameter int N_NEURONS = AER_N_NEURONS,
    parameter int ADDR_W    = AER_ADDR_W,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spike_in,
    input  logic [ADDR_W-1:0]    address_in,
    output logic                 ack_out,
    input  logic                 dest_ready,
    output logic [N_NEURONS-1:0] spikes_out,
    output logic                 addr_err,
    output logic [CNT_W-1:0]     event_count
);

    logic                 req;
    aer_state_t           state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 ack_q;
    logic [N_NEURONS-1:0] spikes_q;
    logic                 addr_err_q;
    logic [CNT_W-1:0]     count_q;

    logic [N_NEURONS-1:0] onehot_in;
    logic [N_NEURONS-1:0] onehot_hold;
    logic                 in_range_in;
    logic [CNT_W-1:0]     count_d;
    logic                 release_d;

`ifdef AER_RX_SYNC_EN
    aer_req_sync u_req_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (spike_in),
        .sync_o  (req)
    );
`else
    assign req = spike_in;
`endif

    // Decode both the live address and the held address, plus saturating count and ack exit
    always_comb begin
        onehot_in   = '0;
        onehot_hold = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            onehot_in[i]   = aer_onehot_bit(int'(address_in), i);
            onehot_hold[i] = aer_onehot_bit(int'(addr_q), i);
        end
        in_range_in = int'(address_in) < N_NEURONS;
        count_d     = (count_q == '1) ? count_q : count_q + 1'b1;
        release_d   = !req || (address_in != addr_q);
    end

    // Handshake FSM with registered ack, spike pulse, error pulse and event counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ack_q      <= 1'b0;
            spikes_q   <= '0;
            addr_err_q <= 1'b0;
            count_q    <= '0;
        end else begin
            spikes_q   <= '0;
            addr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q <= address_in;
                        if (!in_range_in) begin
                            addr_err_q <= 1'b1;
                            ack_q      <= 1'b1;
                            state_q    <= ACK;
                        end else if (dest_ready) begin
                            spikes_q <= onehot_in;
                            count_q  <= count_d;
                            ack_q    <= 1'b1;
                            state_q  <= ACK;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dest_ready) begin
                        spikes_q <= onehot_hold;
                        count_q  <= count_d;
                        ack_q    <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    if (release_d) begin
                        ack_q   <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_out     = ack_q;
    assign spikes_out  = spikes_q;
    assign addr_err    = addr_err_q;
    assign event_count = count_q;

endmodule
